// File: rtl/switch_ctrl_seq.sv
// Sequencer for a unit current-switch array: slews the enabled-switch count toward
// an accepted code in bounded steps, with optional rotating (DWA) switch selection.
module switch_ctrl_seq #(
    parameter int N_ARRAY  = 47,
    parameter int CODE_W   = 6,
    parameter int MAX_STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CODE_W-1:0]  code_in,
    input  logic               code_valid,
    output logic               code_ready,
    input  logic               dwa_en,
    output logic [N_ARRAY-1:0] ctrl,
    output logic [CODE_W-1:0]  count,
    output logic               busy,
    output logic               code_sat
);

    // One guard bit keeps sums and differences of count, ptr and step exact.
    localparam int W = CODE_W + 1;
    localparam logic [W-1:0] N_W    = W'(N_ARRAY);
    localparam logic [W-1:0] STEP_W = W'(MAX_STEP);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_SLEW = 2'd2;

    logic [1:0]         r_state;
    logic [CODE_W-1:0]  r_count;
    logic [CODE_W-1:0]  r_target;
    logic [CODE_W-1:0]  r_ptr;
    logic [N_ARRAY-1:0] r_ctrl;
    logic               r_sat;

    logic [1:0]         w_state_next;
    logic [CODE_W-1:0]  w_count_next;
    logic [CODE_W-1:0]  w_target_next;
    logic [CODE_W-1:0]  w_ptr_next;
    logic [N_ARRAY-1:0] w_ctrl_next;
    logic               w_sat_next;

    logic               w_accept;
    logic               w_code_over;
    logic [CODE_W-1:0]  w_target_acc;
    logic [W-1:0]       w_ptr_sum;
    logic [CODE_W-1:0]  w_ptr_acc;
    logic [W-1:0]       w_cnt_ext;
    logic [W-1:0]       w_tgt_ext;
    logic               w_up;
    logic [CODE_W-1:0]  w_step_up;
    logic [CODE_W-1:0]  w_step_dn;
    logic [CODE_W-1:0]  w_step;
    logic [W-1:0]       w_ptr_next_ext;
    logic [W-1:0]       w_cnt_next_ext;

    assign w_accept     = code_valid && (r_state == ST_IDLE);
    assign w_code_over  = {1'b0, code_in} > N_W;
    assign w_target_acc = w_code_over ? CODE_W'(N_ARRAY) : code_in;

    // Rotation advances past the switches used by the previous code.
    assign w_ptr_sum = {1'b0, r_ptr} + {1'b0, r_count};
    assign w_ptr_acc = !dwa_en          ? '0 :
                       (w_ptr_sum >= N_W) ? CODE_W'(w_ptr_sum - N_W) : CODE_W'(w_ptr_sum);

    assign w_cnt_ext = {1'b0, r_count};
    assign w_tgt_ext = {1'b0, r_target};
    assign w_up      = w_tgt_ext > w_cnt_ext;
    assign w_step_up = ((w_tgt_ext - w_cnt_ext) <= STEP_W) ? r_target
                                                           : CODE_W'(w_cnt_ext + STEP_W);
    assign w_step_dn = ((w_cnt_ext - w_tgt_ext) <= STEP_W) ? r_target
                                                           : CODE_W'(w_cnt_ext - STEP_W);
    assign w_step    = w_up ? w_step_up : w_step_dn;

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_target_next = r_target;
        w_ptr_next    = r_ptr;
        w_sat_next    = 1'b0;
        case (r_state)
            ST_INIT: w_state_next = ST_IDLE;
            ST_IDLE: begin
                if (w_accept) begin
                    w_target_next = w_target_acc;
                    w_ptr_next    = w_ptr_acc;
                    w_sat_next    = w_code_over;
                    w_state_next  = (w_target_acc == r_count) ? ST_IDLE : ST_SLEW;
                end
            end
            ST_SLEW: begin
                w_count_next = w_step;
                if (w_step == r_target) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    assign w_ptr_next_ext = {1'b0, w_ptr_next};
    assign w_cnt_next_ext = {1'b0, w_count_next};

    // Switch k is on when its distance past ptr (modulo the array) is below count.
    for (genvar gi = 0; gi < N_ARRAY; gi++) begin : g_mask
        localparam logic [W-1:0] K = W'(gi);
        logic [W-1:0] w_rel;
        assign w_rel = (K >= w_ptr_next_ext) ? (K - w_ptr_next_ext)
                                             : (K + N_W - w_ptr_next_ext);
        assign w_ctrl_next[gi] = w_rel < w_cnt_next_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_INIT;
            r_count  <= '0;
            r_target <= '0;
            r_ptr    <= '0;
            r_ctrl   <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_target <= w_target_next;
            r_ptr    <= w_ptr_next;
            r_ctrl   <= w_ctrl_next;
            r_sat    <= w_sat_next;
        end
    end

    assign code_ready = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_SLEW);
    assign ctrl       = r_ctrl;
    assign count      = r_count;
    assign code_sat   = r_sat;

endmodule

// File: tb/tb_switch_ctrl_seq.sv
// Directed bench for switch_ctrl_seq: reset, ramps, saturation, DWA rotation/wrap
// and asynchronous reset during a slew.
module tb_switch_ctrl_seq;

    localparam int N_ARRAY  = 47;
    localparam int CODE_W   = 6;
    localparam int MAX_STEP = 4;

    logic               clk;
    logic               rst;
    logic [CODE_W-1:0]  code_in;
    logic               code_valid;
    logic               code_ready;
    logic               dwa_en;
    logic [N_ARRAY-1:0] ctrl;
    logic [CODE_W-1:0]  count;
    logic               busy;
    logic               code_sat;

    int n_vec = 0;
    int n_err = 0;

    switch_ctrl_seq #(
        .N_ARRAY  (N_ARRAY),
        .CODE_W   (CODE_W),
        .MAX_STEP (MAX_STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .dwa_en     (dwa_en),
        .ctrl       (ctrl),
        .count      (count),
        .busy       (busy),
        .code_sat   (code_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int code);
        code_in    = CODE_W'(code);
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!code_ready && n < budget) begin
            tick();
            n++;
        end
        check_vec("idle_within_budget", 64'(code_ready), 64'd1);
    endtask

    function automatic logic [63:0] ones(input int n);
        logic [63:0] one;
        one = 64'd1;
        return (n <= 0) ? 64'd0 : ((one << n) - 64'd1);
    endfunction

    initial begin
        int exp_cnt;
        rst        = 1'b1;
        code_in    = '0;
        code_valid = 1'b0;
        dwa_en     = 1'b0;

        // Reset state before any clock edge, then held across edges
        #3;
        check_vec("rst_ctrl", 64'(ctrl), 64'd0);
        check_vec("rst_count", 64'(count), 64'd0);
        check_vec("rst_ready", 64'(code_ready), 64'd0);
        check_vec("rst_busy", 64'(busy), 64'd0);
        check_vec("rst_sat", 64'(code_sat), 64'd0);
        tick();
        tick();
        check_vec("rst_held_ready", 64'(code_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_vec("init_ready_pre_edge", 64'(code_ready), 64'd0);
        tick();
        check_vec("init_ready_one_edge", 64'(code_ready), 64'd1);

        // Ramp up 0 -> 10, no rotation
        accept(10);
        check_vec("up_busy0", 64'(busy), 64'd1);
        check_vec("up_count0", 64'(count), 64'd0);
        tick();
        check_vec("up_count1", 64'(count), 64'd4);
        check_vec("up_ctrl1", 64'(ctrl), 64'h00F);
        check_vec("up_busy1", 64'(busy), 64'd1);
        tick();
        check_vec("up_count2", 64'(count), 64'd8);
        check_vec("up_ctrl2", 64'(ctrl), 64'h0FF);
        check_vec("up_busy2", 64'(busy), 64'd1);
        tick();
        check_vec("up_count3", 64'(count), 64'd10);
        check_vec("up_ctrl3", 64'(ctrl), 64'h3FF);
        check_vec("up_busy3", 64'(busy), 64'd0);
        check_vec("up_ready3", 64'(code_ready), 64'd1);

        // Back to zero
        accept(0);
        wait_idle(20);
        check_vec("down10_count", 64'(count), 64'd0);

        // Saturation: 60 clamps to 47
        accept(60);
        check_vec("sat_pulse", 64'(code_sat), 64'd1);
        check_vec("sat_busy", 64'(busy), 64'd1);
        tick();
        check_vec("sat_pulse_end", 64'(code_sat), 64'd0);
        check_vec("sat_count1", 64'(count), 64'd4);
        wait_idle(20);
        check_vec("sat_count_final", 64'(count), 64'd47);
        check_vec("sat_ctrl_final", 64'(ctrl), 64'h7FFF_FFFF_FFFF);

        // Ramp down 47 -> 0 with code_valid held during the slew
        accept(0);
        code_in    = CODE_W'(20);
        code_valid = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_cnt = 47 - 4 * i;
            if (exp_cnt < 0) exp_cnt = 0;
            check_vec($sformatf("dn_count%0d", i), 64'(count), 64'(exp_cnt));
            check_vec($sformatf("dn_ctrl%0d", i), 64'(ctrl), ones(exp_cnt));
            check_vec($sformatf("dn_busy%0d", i), 64'(busy), (i < 12) ? 64'd1 : 64'd0);
        end
        code_valid = 1'b0;
        check_vec("dn_ready", 64'(code_ready), 64'd1);

        // DWA from a fresh reset
        rst = 1'b1;
        #2;
        check_vec("dwa_rst_ctrl", 64'(ctrl), 64'd0);
        rst    = 1'b0;
        dwa_en = 1'b1;
        tick();
        check_vec("dwa_ready", 64'(code_ready), 64'd1);
        accept(5);
        wait_idle(10);
        check_vec("dwa_ctrl_5a", 64'(ctrl), 64'h1F);
        accept(5);
        check_vec("dwa_same_ready", 64'(code_ready), 64'd1);
        check_vec("dwa_same_busy", 64'(busy), 64'd0);
        check_vec("dwa_ctrl_5b", 64'(ctrl), 64'h3E0);
        accept(35);
        dwa_en = 1'b0;
        wait_idle(20);
        check_vec("dwa_count_35", 64'(count), 64'd35);
        check_vec("dwa_ctrl_35", 64'(ctrl), 64'h1FFF_FFFF_FC00);
        dwa_en = 1'b1;
        accept(4);
        tick();
        check_vec("dwa_wrap_step1", 64'(ctrl), 64'h6000_1FFF_FFFF);
        wait_idle(20);
        check_vec("dwa_wrap_count", 64'(count), 64'd4);
        check_vec("dwa_wrap_ctrl", 64'(ctrl), 64'h6000_0000_0003);

        // Asynchronous reset in the middle of a 0 -> 40 slew
        dwa_en = 1'b0;
        rst    = 1'b1;
        #2;
        rst    = 1'b0;
        tick();
        accept(40);
        tick();
        tick();
        check_vec("mid_count", 64'(count), 64'd8);
        #2;
        rst = 1'b1;
        #1;
        check_vec("mid_rst_ctrl", 64'(ctrl), 64'd0);
        check_vec("mid_rst_busy", 64'(busy), 64'd0);
        check_vec("mid_rst_count", 64'(count), 64'd0);
        check_vec("mid_rst_ready", 64'(code_ready), 64'd0);
        #1;
        rst = 1'b0;
        tick();
        check_vec("mid_ready", 64'(code_ready), 64'd1);
        accept(8);
        check_vec("mid_busy", 64'(busy), 64'd1);
        tick();
        check_vec("mid_count1", 64'(count), 64'd4);
        check_vec("mid_ctrl1", 64'(ctrl), 64'h0F);
        tick();
        check_vec("mid_count2", 64'(count), 64'd8);
        check_vec("mid_ctrl2", 64'(ctrl), 64'hFF);
        check_vec("mid_ready2", 64'(code_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
